panda_ram_arbiter: RTL and testbench
====================================

PANDA_RAM_ARBITER -- requirements
Module: panda_ram_arbiter

Interface
REQ-001 The block SHALL have parameter DataWidth, default 32, giving the data width in bits of both requester ports and the RAM port.
REQ-002 The block SHALL have parameter Depth, default 64, giving the RAM depth in words; AW = $clog2(Depth).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port req_i, input, [1:0]: access request, one bit per requester p (p = 0, 1).
REQ-006 The block SHALL have port we_i, input, [1:0][DataWidth/8]: byte write enables per requester; all zero means read.
REQ-007 The block SHALL have port addr_i, input, [1:0][AW]: word address per requester.
REQ-008 The block SHALL have port wdata_i, input, [1:0][DataWidth]: write data per requester.
REQ-009 The block SHALL have port gnt_o, output, [1:0]: combinational grant, one bit per requester.
REQ-010 The block SHALL have port rvalid_o, output, [1:0]: read data valid, one bit per requester.
REQ-011 The block SHALL have port rdata_o, output, DataWidth bits: read data, shared by both requesters and qualified by rvalid_o.
REQ-012 The block SHALL have RAM-side ports ram_ce_o (output, 1), ram_we_o (output, DataWidth/8), ram_addr_o (output, AW) and ram_data_o (output, DataWidth), driving the single-port RAM.
REQ-013 The block SHALL have port ram_data_i, input, DataWidth bits: RAM read data, valid one cycle after an enabled read.

Function
REQ-014 At most one bit of gnt_o SHALL be set in any cycle; gnt_o[p] SHALL only be set while req_i[p] = 1.
REQ-015 If exactly one requester asserts req_i, that requester SHALL be granted in the same cycle, regardless of priority state.
REQ-016 If both requesters assert req_i, the port selected by the registered priority pointer prio_q SHALL be granted.
REQ-017 After any grant to port p, prio_q SHALL become 1-p at the next edge; with no grant, prio_q SHALL hold its value.
REQ-018 While port p is granted: ram_ce_o = 1, ram_we_o = we_i[p], ram_addr_o = addr_i[p], ram_data_o = wdata_i[p]. With no grant, all RAM-side outputs SHALL be 0.
REQ-019 A granted read (we_i[p] = 0) SHALL set rvalid_o[p] = 1 exactly one cycle later, with rdata_o = ram_data_i in that cycle.
REQ-020 A granted write SHALL complete in the grant cycle and SHALL never produce rvalid_o.
REQ-021 rdata_o SHALL be 0 whenever rvalid_o = 0; both bits of rvalid_o SHALL never be set together.
REQ-022 Requests are not stored: a requester SHALL hold req/we/addr/wdata until gnt_o[p] is set; the arbiter SHALL sustain one access per cycle back to back.
REQ-023 In round-robin mode, a requester holding req_i continuously SHALL be granted within 2 cycles.

Reset
REQ-024 While rst_i = 1: prio_q = 0, the registered rvalid state = 0, gnt_o = 0, rvalid_o = 0, rdata_o = 0, and all RAM-side outputs = 0.
REQ-025 Reset asserted while a read is in flight SHALL discard that read; no rvalid_o SHALL be produced after reset deasserts.
REQ-026 The first arbitration after reset deasserts SHALL favour port 0.

Configuration
REQ-027 When macro PANDA_RAM_ARB_FIXED_PRIO_EN is defined, port 0 SHALL always win on contention, and prio_q SHALL be omitted.
REQ-028 When PANDA_RAM_ARB_FIXED_PRIO_EN is undefined, round-robin per REQ-016 and REQ-017 SHALL apply.

Verification
REQ-029 Single read: port 1 reads addr 5, RAM word 5 = 0x12345678 -> gnt_o = 2'b10 in the same cycle; next cycle rvalid_o = 2'b10 and rdata_o = 0x12345678.
REQ-030 Contention (round-robin): both ports request reads for 4 cycles after reset -> grants go 0, 1, 0, 1; rvalid_o follows each grant by one cycle.
REQ-031 Byte write: port 0 writes addr 41 with we = 4'b0011 and data 0xABCDEF89, then reads addr 41 -> low half becomes 0xEF89, upper bytes unchanged, and the write produces no rvalid_o.
REQ-032 Reset mid-read: read granted, rst_i pulsed before the next edge -> rvalid_o stays 0 and prio_q = 0 afterwards.
REQ-033 With PANDA_RAM_ARB_FIXED_PRIO_EN defined, both ports requesting for 3 cycles -> port 0 is granted every cycle and port 1 is never granted.

Source files
------------

// File: rtl/panda_ram_arbiter.sv
// panda_ram_arbiter: two requesters sharing one single-port RAM, one access per cycle.
// Define PANDA_RAM_ARB_FIXED_PRIO_EN to make port 0 always win on contention.
module panda_ram_arbiter #(
    parameter int DataWidth = 32,
    parameter int Depth     = 64,
    localparam int AW       = $clog2(Depth),
    localparam int BW       = DataWidth / 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [1:0]                req_i,
    input  logic [1:0][BW-1:0]        we_i,
    input  logic [1:0][AW-1:0]        addr_i,
    input  logic [1:0][DataWidth-1:0] wdata_i,
    output logic [1:0]                gnt_o,
    output logic [1:0]                rvalid_o,
    output logic [DataWidth-1:0]      rdata_o,
    output logic                      ram_ce_o,
    output logic [BW-1:0]             ram_we_o,
    output logic [AW-1:0]             ram_addr_o,
    output logic [DataWidth-1:0]      ram_data_o,
    input  logic [DataWidth-1:0]      ram_data_i
);

    logic [1:0] gnt;
    logic       sel;
    logic [1:0] rvalid_d, rvalid_q;

`ifndef PANDA_RAM_ARB_FIXED_PRIO_EN
    logic prio_q, prio_d;
`endif

    // Pick the winner: a lone requester always wins, contention goes to the favoured port
    always_comb begin
        gnt = 2'b00;
        if (!rst_i) begin
            case (req_i)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
`ifdef PANDA_RAM_ARB_FIXED_PRIO_EN
                2'b11:   gnt = 2'b01;
`else
                2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
`endif
                default: gnt = 2'b00;
            endcase
        end
    end

    assign sel = gnt[1];

    // Steer the granted port onto the RAM; an idle cycle drives all zeros
    always_comb begin
        ram_ce_o   = 1'b0;
        ram_we_o   = '0;
        ram_addr_o = '0;
        ram_data_o = '0;
        if (gnt != 2'b00) begin
            ram_ce_o   = 1'b1;
            ram_we_o   = we_i[sel];
            ram_addr_o = addr_i[sel];
            ram_data_o = wdata_i[sel];
        end
    end

    // A granted read returns its data one cycle later; writes never answer
    always_comb begin
        rvalid_d[0] = gnt[0] & ~(|we_i[0]);
        rvalid_d[1] = gnt[1] & ~(|we_i[1]);
    end

    // Track which port owns the RAM read data arriving next cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 2'b00;
        end else begin
            rvalid_q <= rvalid_d;
        end
    end

`ifndef PANDA_RAM_ARB_FIXED_PRIO_EN
    // The loser of the last grant is favoured next; idle cycles keep the pointer
    always_comb begin
        prio_d = prio_q;
        if (gnt[0]) begin
            prio_d = 1'b1;
        end else if (gnt[1]) begin
            prio_d = 1'b0;
        end
    end

    // Round-robin pointer, starting in favour of port 0
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    assign gnt_o    = gnt;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = (|rvalid_q) ? ram_data_i : '0;

endmodule

// File: tb/tb_panda_ram_arbiter.sv
// tb_panda_ram_arbiter: random two-port traffic against a shadow-memory reference.
// Honours PANDA_RAM_ARB_FIXED_PRIO_EN when compiled together with the RTL.
module tb_panda_ram_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int BW    = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           req;
    logic [1:0][BW-1:0]   we;
    logic [1:0][AW-1:0]   addr;
    logic [1:0][DW-1:0]   wdata;
    logic [1:0]           gnt;
    logic [1:0]           rvalid;
    logic [DW-1:0]        rdata;
    logic                 ram_ce;
    logic [BW-1:0]        ram_we;
    logic [AW-1:0]        ram_addr;
    logic [DW-1:0]        ram_wdata;
    logic [DW-1:0]        ram_rdata;

    always #5 clk = ~clk;

    panda_ram_arbiter #(.DataWidth(DW), .Depth(DEPTH)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .we_i       (we),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .gnt_o      (gnt),
        .rvalid_o   (rvalid),
        .rdata_o    (rdata),
        .ram_ce_o   (ram_ce),
        .ram_we_o   (ram_we),
        .ram_addr_o (ram_addr),
        .ram_data_o (ram_wdata),
        .ram_data_i (ram_rdata)
    );

    // Single-port RAM with byte enables and one-cycle read latency
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we != '0) begin
                for (int b = 0; b < BW; b++)
                    if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    typedef struct {
        int          port;
        logic [DW-1:0] data;
        int          cyc;
    } exp_t;

    logic [DW-1:0] ref_mem [DEPTH];
    exp_t          expq[$];
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;
    int            favour = 0;
    logic [1:0]    last_gnt;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every read answer must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rvalid == 2'b00) begin
            chk("rdata_idle_zero", 128'(rdata), 128'(0));
            if (expq.size() > 0 && expq[0].cyc <= cyc) begin
                chk("rvalid_missing", 128'(rvalid), 128'(2'b01 << expq[0].port));
                void'(expq.pop_front());
            end
        end else if (expq.size() == 0 || expq[0].cyc != cyc) begin
            chk("rvalid_spurious", 128'(rvalid), 128'(0));
        end else begin
            e = expq.pop_front();
            chk("rvalid", 128'(rvalid), 128'(2'b01 << e.port));
            chk("rdata", 128'(rdata), 128'(e.data));
        end
    end

    // Reference: decide the winner from the rules, check the RAM side, update shadow memory
    task automatic check_cycle(output int g);
        logic [1:0] eg;
        @(negedge clk);
        g = -1;
        if (!rst) begin
            if (req == 2'b01) g = 0;
            else if (req == 2'b10) g = 1;
            else if (req == 2'b11) g = favour;
        end
        eg = (g < 0) ? 2'b00 : 2'(2'b01 << g);
        last_gnt = gnt;
        chk("gnt", 128'(gnt), 128'(eg));
        if (g < 0) begin
            chk("ram_idle", 128'({ram_ce, ram_we, ram_addr, ram_wdata}), 128'(0));
        end else begin
            chk("ram_port", 128'({ram_ce, ram_we, ram_addr, ram_wdata}),
                128'({1'b1, we[g], addr[g], wdata[g]}));
            if (we[g] != '0) begin
                for (int b = 0; b < BW; b++)
                    if (we[g][b]) ref_mem[addr[g]][8*b +: 8] = wdata[g][8*b +: 8];
            end else begin
                expq.push_back('{g, ref_mem[addr[g]], cyc + 1});
            end
`ifdef PANDA_RAM_ARB_FIXED_PRIO_EN
            favour = 0;
`else
            favour = 1 - g;
`endif
        end
    endtask

    task automatic newreq(input int p);
        req[p]   = 1'b1;
        we[p]    = ($urandom_range(0, 1) == 1) ? BW'($urandom_range(1, 15)) : '0;
        addr[p]  = AW'($urandom_range(0, 15));
        wdata[p] = $urandom;
    endtask

    // Requesters hold until granted; in random mode they then re-roll
    task automatic advance(input bit autogen, input int g);
        @(posedge clk);
        #1;
        if (autogen) begin
            for (int p = 0; p < 2; p++) begin
                if (p == g || !req[p]) begin
                    if ($urandom_range(0, 3) != 0) newreq(p);
                    else req[p] = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input bit autogen);
        int g;
        check_cycle(g);
        advance(autogen, g);
    endtask

    initial begin
        logic [1:0] expv [4];
        int g;
        rst   = 1'b1;
        req   = 2'b11;
        we    = '0;
        addr  = '0;
        wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [DW-1:0] v;
            v = $urandom;
            if (i == 5) v = 32'h12345678;
            if (i == 41) v = 32'h11223344;
            mem[i]     <= v;
            ref_mem[i]  = v;
        end
        #1;
        repeat (2) step(1'b0);
        rst = 1'b0;

        // Both ports read for four cycles straight out of reset
`ifdef PANDA_RAM_ARB_FIXED_PRIO_EN
        expv = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        expv = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        req = 2'b11;
        addr[0] = 6'd3;
        addr[1] = 6'd7;
        for (int i = 0; i < 4; i++) begin
            check_cycle(g);
            chk("contention_gnt", 128'(last_gnt), 128'(expv[i]));
            advance(1'b0, g);
        end
        req = 2'b00;

        // Lone read from port 1
        req = 2'b10;
        addr[1] = 6'd5;
        check_cycle(g);
        chk("single_read_gnt", 128'(last_gnt), 128'(2'b10));
        advance(1'b0, g);
        req = 2'b00;

        // Byte write to the low half, then read it back
        req = 2'b01;
        we[0] = 4'b0011;
        addr[0] = 6'd41;
        wdata[0] = 32'hABCDEF89;
        step(1'b0);
        we[0] = 4'b0000;
        step(1'b0);
        req = 2'b00;
        step(1'b0);

        // Reset pulse while a read is in flight
        req = 2'b01;
        addr[0] = 6'd9;
        check_cycle(g);
        #1;
        rst = 1'b1;
        req = 2'b00;
        expq.delete();
        favour = 0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0);
        req = 2'b11;
        addr[0] = 6'd2;
        addr[1] = 6'd4;
        check_cycle(g);
        chk("prio_after_reset", 128'(last_gnt), 128'(2'b01));
        advance(1'b0, g);
        req = 2'b00;
        step(1'b0);

        // Random traffic
        newreq(0);
        newreq(1);
        repeat (3000) step(1'b1);
        req = 2'b00;
        repeat (3) step(1'b0);
        chk("queue_drained", 128'(expq.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
